// File: rtl/dram_cache_write_arbiter.sv
// DRAM-cache write-channel arbiter: read-miss fill path vs write path,
// one registered output beat, fill priority, optional write starvation guard.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   fill_valid_i/ready_o/data_i  fill requester (refill lines from memory)
//   wr_valid_i/ready_o/data_i    write requester (write hit/miss path)
//   valid_o, ready_i, data_o     registered beat toward cache write port
//   src_o                        source of data_o: 0 = fill, 1 = write
//
// Build option: define WR_ARB_STARVE_GUARD_EN to force a write grant after
// STARVE_LIMIT consecutive fill grants while a write is waiting.
module dram_cache_write_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int LINE_W       = 512,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fill_valid_i,
    output logic                     fill_ready_o,
    input  logic [ADDR_W+LINE_W-1:0] fill_data_i,
    input  logic                     wr_valid_i,
    output logic                     wr_ready_o,
    input  logic [ADDR_W+LINE_W-1:0] wr_data_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [ADDR_W+LINE_W-1:0] data_o,
    output logic                     src_o
);

    localparam int BW = ADDR_W + LINE_W;

    logic slot_free;
    logic force_wr;
    logic grant_fill;
    logic grant_wr;

    // The output slot can take a new beat if empty or draining this edge.
    assign slot_free = !valid_o || ready_i;

`ifdef WR_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_cnt;

    // Counts fill grants taken while a write is waiting; once it
    // saturates, the next free slot goes to the write.
    assign force_wr = wr_valid_i && (starve_cnt == CW'(STARVE_LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!wr_valid_i || wr_ready_o) begin
            starve_cnt <= '0;
        end else if (fill_ready_o && (starve_cnt != CW'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign force_wr = 1'b0;
`endif

    assign grant_fill = fill_valid_i && !force_wr;
    assign grant_wr   = wr_valid_i && (!fill_valid_i || force_wr);

    // Readies are held low during reset even though the slot looks free.
    assign fill_ready_o = rst_n && slot_free && grant_fill;
    assign wr_ready_o   = rst_n && slot_free && grant_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            src_o   <= 1'b0;
        end else if (slot_free) begin
            if (fill_ready_o) begin
                valid_o <= 1'b1;
                data_o  <= fill_data_i;
                src_o   <= 1'b0;
            end else if (wr_ready_o) begin
                valid_o <= 1'b1;
                data_o  <= wr_data_i;
                src_o   <= 1'b1;
            end else begin
                valid_o <= 1'b0;
            end
        end
    end

    // Width sanity for the beat register.
    logic [BW-1:0] beat_width_chk;
    assign beat_width_chk = data_o;
    logic unused_ok;
    assign unused_ok = ^beat_width_chk;

endmodule

// File: tb/tb_dram_cache_write_arbiter.sv
// Scoreboard bench for dram_cache_write_arbiter: a per-cycle arbitration
// model predicts readies and queues expected beats; a monitor checks output.
module tb_dram_cache_write_arbiter;

    localparam int ADDR_W = 64;
    localparam int LINE_W = 512;
    localparam int LIMIT  = 4;
    localparam int BW     = ADDR_W + LINE_W;

    typedef logic [BW-1:0] beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fill_valid_i = 1'b0;
    logic        fill_ready_o;
    beat_t       fill_data_i = '0;
    logic        wr_valid_i = 1'b0;
    logic        wr_ready_o;
    beat_t       wr_data_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    beat_t       data_o;
    logic        src_o;

    dram_cache_write_arbiter #(
        .ADDR_W(ADDR_W),
        .LINE_W(LINE_W),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .fill_valid_i(fill_valid_i),
        .fill_ready_o(fill_ready_o),
        .fill_data_i(fill_data_i),
        .wr_valid_i(wr_valid_i),
        .wr_ready_o(wr_ready_o),
        .wr_data_i(wr_data_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .data_o(data_o),
        .src_o(src_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Expected beats in output order: {src, data}.
    logic [BW:0] exp_q[$];

    // Reference state: is a beat sitting in the output slot, and how many
    // fills have overtaken the currently waiting write.
    logic m_busy = 1'b0;
    int   m_overtaken = 0;

    // Requester state for randomized phases.
    logic  cur_fv = 1'b0, cur_wv = 1'b0, cur_fa = 1'b0, cur_wa = 1'b0;
    beat_t cur_fd = '0, cur_wd = '0;
    int    wr_grants = 0;

    task automatic chk(input string nm, input logic [BW:0] act,
                       input logic [BW:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic beat_t rnd_beat();
        beat_t b;
        for (int k = 0; k < BW / 32; k++) b[k*32 +: 32] = $urandom;
        return b;
    endfunction

    // Drive one cycle's inputs (called just after a falling edge),
    // predict and check readies, queue accepted beats.
    task automatic step(input logic fv, input beat_t fd, input logic wv,
                        input beat_t wd, input logic rdy,
                        output logic fa, output logic wa);
        logic room, take_w;
        fill_valid_i = fv;
        fill_data_i  = fd;
        wr_valid_i   = wv;
        wr_data_i    = wd;
        ready_i      = rdy;
        #1;
        room = !m_busy || rdy;
        take_w = wv && !fv;
`ifdef WR_ARB_STARVE_GUARD_EN
        if (wv && m_overtaken >= LIMIT) take_w = 1'b1;
`endif
        fa = room && fv && !take_w;
        wa = room && take_w;
        chk("fill_ready", {{BW{1'b0}}, fill_ready_o}, {{BW{1'b0}}, fa});
        chk("wr_ready", {{BW{1'b0}}, wr_ready_o}, {{BW{1'b0}}, wa});
        if (fa) exp_q.push_back({1'b0, fd});
        if (wa) begin
            exp_q.push_back({1'b1, wd});
            wr_grants++;
        end
        if (fa || wa) m_busy = 1'b1;
        else if (room) m_busy = 1'b0;
        if (!wv || wa) m_overtaken = 0;
        else if (fa) m_overtaken++;
    endtask

    // mode 0: random valids/ready; mode 1: both always valid, ready 1.
    task automatic run_phase(input int n, input int mode);
        logic rdy;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!cur_fv || cur_fa) begin
                cur_fv = (mode == 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
                cur_fd = rnd_beat();
            end
            if (!cur_wv || cur_wa) begin
                cur_wv = (mode == 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
                cur_wd = rnd_beat();
            end
            rdy = (mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
            step(cur_fv, cur_fd, cur_wv, cur_wd, rdy, cur_fa, cur_wa);
        end
    endtask

    // Reset with both requesters valid; everything registered is dropped.
    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        fill_valid_i = 1'b1;
        wr_valid_i   = 1'b1;
        ready_i      = 1'b1;
        #1;
        exp_q.delete();
        m_busy = 1'b0;
        m_overtaken = 0;
        cur_fa = 1'b0;
        cur_wa = 1'b0;
        chk("rst_valid", {{BW{1'b0}}, valid_o}, '0);
        chk("rst_data", {1'b0, data_o}, '0);
        chk("rst_src", {{BW{1'b0}}, src_o}, '0);
        chk("rst_fill_ready", {{BW{1'b0}}, fill_ready_o}, '0);
        chk("rst_wr_ready", {{BW{1'b0}}, wr_ready_o}, '0);
        @(posedge clk);
        #2;
        chk("rst_hold_valid", {{BW{1'b0}}, valid_o}, '0);
        chk("rst_hold_ready", {{BW{1'b0}}, fill_ready_o | wr_ready_o}, '0);
        rst_n = 1'b1;
    endtask

    // Monitor: whenever the DUT shows a beat, it must be the oldest
    // expected one; it leaves the queue when ready_i takes it.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && valid_o) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_beat act=%h exp=none",
                             {src_o, data_o});
                end else begin
                    chk("out_beat", {src_o, data_o}, exp_q[0]);
                    if (ready_i) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t f1, w1, a, b;
        logic fa, wa;
        int wg;

        do_reset();

        // Single fill right after reset.
        f1 = {64'hab, 512'hcc};
        @(negedge clk); step(1'b1, f1, 1'b0, '0, 1'b1, fa, wa);
        @(negedge clk); step(1'b0, '0, 1'b0, '0, 1'b1, fa, wa);
        @(negedge clk); step(1'b0, '0, 1'b0, '0, 1'b1, fa, wa);

        // Collision: fill first, write on the following edge.
        f1 = {64'h11, 512'h33};
        w1 = {64'h22, 512'h44};
        @(negedge clk); step(1'b1, f1, 1'b1, w1, 1'b1, fa, wa);
        @(negedge clk); step(1'b0, '0, 1'b1, w1, 1'b1, fa, wa);
        @(negedge clk); step(1'b0, '0, 1'b0, '0, 1'b1, fa, wa);
        @(negedge clk); step(1'b0, '0, 1'b0, '0, 1'b1, fa, wa);

        // Backpressure: hold beat a for 3 cycles, then drain and load b.
        a = rnd_beat();
        b = rnd_beat();
        @(negedge clk); step(1'b1, a, 1'b0, '0, 1'b1, fa, wa);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); step(1'b1, b, 1'b1, a, 1'b0, fa, wa);
        end
        @(negedge clk); step(1'b1, b, 1'b1, a, 1'b1, fa, wa);
        @(negedge clk); step(1'b0, '0, 1'b1, a, 1'b1, fa, wa);
        @(negedge clk); step(1'b0, '0, 1'b0, '0, 1'b1, fa, wa);

        // Saturated contention: starvation guard behaviour.
        cur_fv = 1'b0;
        cur_wv = 1'b0;
        wr_grants = 0;
        run_phase(30, 1);
        wg = wr_grants;
`ifdef WR_ARB_STARVE_GUARD_EN
        chk("sat_wr_grants", (BW + 1)'(wg), (BW + 1)'(30 / (LIMIT + 1)));
`else
        chk("sat_wr_grants", (BW + 1)'(wg), '0);
`endif

        // Random traffic, a mid-run reset, more random traffic.
        run_phase(300, 0);
        do_reset();
        run_phase(300, 0);

        // Drain and confirm nothing was lost.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); step(1'b0, '0, 1'b0, '0, 1'b1, fa, wa);
        end
        @(negedge clk);
        #3;
        chk("queue_empty", (BW + 1)'(exp_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dram_cache_write_arbiter.md
# dram_cache_write_arbiter

Two-to-one arbiter sharing the single DRAM-cache write channel between the read-miss fill path (refill lines returned from main memory) and the write-miss/write-hit path. It sits downstream of the read miss handler's arbiter-side valid/ready output and in front of the cache array write port. It registers one beat, gives read-miss fills priority, and prevents write starvation when the guard feature is compiled in.

## Interface
- ADDR_W, 64, address field width of a beat
- LINE_W, 512, cache line data width
- STARVE_LIMIT, 4, consecutive fill grants tolerated while a write waits (guard feature only)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- fill_valid_i  in  1  read-miss fill beat valid
- fill_ready_o  out  1  fill beat accepted this cycle
- fill_data_i  in  ADDR_W+LINE_W  {address[575:512], line[511:0]}
- wr_valid_i  in  1  write-path beat valid
- wr_ready_o  out  1  write beat accepted this cycle
- wr_data_i  in  ADDR_W+LINE_W  same format as fill_data_i
- valid_o  out  1  beat valid toward cache write port
- ready_i  in  1  cache write port accepts beat
- data_o  out  ADDR_W+LINE_W  registered winning beat
- src_o  out  1  source of data_o: 0 = fill, 1 = write

## Operation
- One output register (valid_o, data_o, src_o). slot_free = !valid_o || ready_i.
- Grant evaluated combinationally each cycle only when slot_free; no grant otherwise, both ready outputs 0.
- Default priority: fill wins when both valid; write granted only when fill_valid_i is 0 (or guard forces it).
- Ready outputs: at most one high per cycle; fill_ready_o = slot_free & fill_valid_i & grant_fill; wr_ready_o likewise. Never both.
- On acceptance: data_o <= winner's data, src_o <= winner id, valid_o <= 1.
- If slot_free and no input valid: valid_o <= 0; data_o, src_o hold.
- Requesters hold valid and data stable until ready; arbiter does not inspect addresses. Same-address ordering between paths is upstream's responsibility.
- Beat format passed through unmodified; no width conversion.
- Reset mid-operation: any registered beat is dropped, valid_o deasserts immediately, counter clears; requesters re-present after reset.

## Timing
- Reset values: valid_o 0, data_o 0, src_o 0, starve counter 0; fill_ready_o and wr_ready_o 0 while rst_n low.
- Latency: input accepted on edge N appears on valid_o/data_o after edge N (visible in cycle N+1).
- Throughput: one beat per cycle while ready_i stays 1 (acceptance and drain on same edge).
- Backpressure: valid_o high and ready_i low -> data_o, src_o stable, both ready outputs 0.
- Ready outputs depend combinationally on ready_i, valid_o and both valid inputs; no combinational path from data inputs to ready.

## Configuration
- Macro WR_ARB_STARVE_GUARD_EN.
- Defined: counter starve_cnt, width clog2(STARVE_LIMIT+1). On a fill grant while wr_valid_i is 1, starve_cnt increments (saturates at STARVE_LIMIT). On a write grant, or any cycle wr_valid_i is 0, starve_cnt clears to 0. When starve_cnt == STARVE_LIMIT and wr_valid_i is 1 and slot_free, write is granted regardless of fill_valid_i. Result: write waits at most STARVE_LIMIT fill grants.
- Undefined: no counter; strict fill priority; write may starve indefinitely under continuous fills. STARVE_LIMIT unused.

## Test plan
- Reset: rst_n low with both valids 1 -> valid_o 0, data_o 0, src_o 0, both readies 0; release -> first grant next cycle.
- Single fill: fill_data_i = {64'hab, 512'hcc}, ready_i 1 -> fill_ready_o 1 for one cycle, next cycle valid_o 1, data_o = {64'hab, 512'hcc}, src_o 0.
- Collision: both valid, fill {64'h11, 512'h33}, write {64'h22, 512'h44}, ready_i 1 -> fill out first (src_o 0), write out next cycle (src_o 1), back-to-back valid_o.
- Backpressure: ready_i 0 for 3 cycles with beat registered -> data_o stable, both readies 0; ready_i 1 -> beat drains and next pending beat loads same edge.
- Guard (macro defined, STARVE_LIMIT 4): fill and write valid continuously, ready_i 1 -> src_o sequence 0,0,0,0,1 repeating.
- Guard off (macro undefined): same stimulus -> src_o 0 every cycle, wr_ready_o never 1.
